ddr_wr_arbiter: RTL and testbench
=================================

// Module: ddr_wr_arbiter
// PURPOSE
//   Shares the single DDR write engine among CH_NUM per-stream write address controllers.
//   Captures each channel's address/length request, grants channels round-robin,
//   issues one command at a time and routes the engine's completion back as a per-channel pulse.
//   Sits between the wrN address controllers and the DDR write burst engine.
// PARAMETERS
//   CH_NUM       4       number of requesting channels (2..8)
//   ADDR_WIDTH   30      DDR byte-address width
//   WR_NUM_WIDTH 28      transfer-length width
//   TIMEOUT_CYC  2**20   watchdog limit in clk cycles (used only with DDR_ARB_TIMEOUT_EN)
// PORTS
//   clk           in   1                      system clock
//   rst           in   1                      synchronous, active-high reset
//   ch_valid      in   CH_NUM                 request level per channel; rising edge = new request
//   ch_addr       in   CH_NUM*ADDR_WIDTH      request address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   ch_num        in   CH_NUM*WR_NUM_WIDTH    request length, same packing
//   ch_done       out  CH_NUM                 1-cycle completion pulse to the owning channel
//   ddr_addr_valid out 1                      1-cycle command strobe to the DDR engine
//   ddr_addr      out  ADDR_WIDTH             command address, held until the next command
//   ddr_num       out  WR_NUM_WIDTH           command length, held until the next command
//   ddr_done      in   1                      engine completion level; rising edge = done
//   busy          out  1                      high in ISSUE/WAIT
//   ovf_err       out  1                      sticky: new request on a channel already pending
// BEHAVIOUR
//   - Reset: all outputs 0. Pending flags and latched addr/num cleared. FSM=IDLE, rr pointer=0.
//   - Request capture: ch_valid edge-detected per channel (1 registered stage). On a rising edge,
//     pending[i]<=1 and ch_addr/ch_num slice latched the same cycle.
//     Edge while pending[i]=1 -> ovf_err<=1, latched values unchanged, request dropped.
//   - Arbitration: round-robin starting at the channel after the last grant. Lowest index wins
//     among ties relative to the pointer. Evaluated only in IDLE.
//   - FSM:
//     IDLE  -> ISSUE when any pending; registers gnt index.
//     ISSUE -> WAIT after 1 cycle: ddr_addr_valid=1 for exactly this cycle, ddr_addr/ddr_num = latched
//              values of gnt, pending[gnt]<=0.
//     WAIT  -> IDLE on ddr_done rising edge: ch_done[gnt]=1 for 1 cycle, rr pointer<=gnt+1 (mod CH_NUM).
//   - Latency: capture edge to ddr_addr_valid = 3 clk when idle (edge reg, IDLE->ISSUE, strobe).
//     Back-to-back: next ddr_addr_valid exactly 2 clk after the ddr_done edge cycle.
//   - A request arriving on gnt in the same cycle pending[gnt] clears is accepted
//     (set has priority over clear). No ovf_err.
//   - ddr_done edges in IDLE/ISSUE are ignored. The ddr_done edge detector runs continuously.
//   - Mid-operation reset: returns to IDLE in 1 cycle. No ch_done emitted. The engine is not aborted.
//   - busy = (state != IDLE).
// CONFIGURATION
//   DDR_ARB_TIMEOUT_EN defined: WAIT counter. Reaching TIMEOUT_CYC without ddr_done edge ->
//     output timeout_err (1 bit, sticky until rst) set, ch_done[gnt] pulsed, FSM->IDLE.
//   Not defined: no counter, no timeout_err port, WAIT holds indefinitely.
// STRUCTURE
//   ddr_arb_pkg: FSM state typedef (IDLE/ISSUE/WAIT), CH_IDX_W = $clog2(CH_NUM) helper.
//   Sub-module rr_picker: combinational round-robin select (pending, pointer -> gnt, any).
//   All other logic stays in the top level.
// TESTING
//   1 Single: ch1 edge, addr 0x0100_0000, num 7200 -> strobe 3 clk later with those values;
//     done edge -> ch_done[1] pulse, busy=0 next clk.
//   2 Contention: ch0..ch3 edges same cycle -> grants in order 0,1,2,3; repeat -> order 0,1,2,3
//     (pointer wraps at 4).
//   3 Overflow: ch2 edge twice before grant -> ovf_err=1, one command for ch2 with first addr.
//   4 Spurious done: ddr_done edge in IDLE -> no ch_done, no state change.
//   5 Reset in WAIT: assert rst -> all outputs 0 next clk; later done edge ignored.
//   6 DDR_ARB_TIMEOUT_EN with TIMEOUT_CYC=16: no done -> timeout_err and ch_done[gnt] at cycle 16
//     of WAIT.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// Shared types for the DDR write arbiter: FSM state encoding and channel-index width helper.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // Index width for a channel count; never below 1 bit.
  function automatic int ch_idx_w(input int ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

endpackage

// File: rtl/ddr_wr_arbiter_rr_picker.sv
// Combinational round-robin selector: first pending channel at or after ptr, wrapping.
module rr_picker
  import ddr_arb_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int IDX_W  = ch_idx_w(CH_NUM)
) (
  input  logic [CH_NUM-1:0] pending,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  gnt,
  output logic              any
);

  int idx;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = (int'(ptr) + k) % CH_NUM;
      if (!any && pending[IDX_W'(idx)]) begin
        any = 1'b1;
        gnt = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// Round-robin sharing of one DDR write engine among CH_NUM address controllers.
// Optional watchdog on the WAIT state: define DDR_ARB_TIMEOUT_EN (adds timeout_err port).
module ddr_wr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int CH_NUM       = 4,
  parameter int ADDR_WIDTH   = 30,
`ifdef DDR_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYC  = 2**20,
`endif
  parameter int WR_NUM_WIDTH = 28
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CH_NUM-1:0]              ch_valid,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]   ch_addr,
  input  logic [CH_NUM*WR_NUM_WIDTH-1:0] ch_num,
  output logic [CH_NUM-1:0]              ch_done,
  output logic                           ddr_addr_valid,
  output logic [ADDR_WIDTH-1:0]          ddr_addr,
  output logic [WR_NUM_WIDTH-1:0]        ddr_num,
  input  logic                           ddr_done,
  output logic                           busy,
`ifdef DDR_ARB_TIMEOUT_EN
  output logic                           timeout_err,
`endif
  output logic                           ovf_err
);

  localparam int IDX_W = ch_idx_w(CH_NUM);

  arb_state_t state, state_nxt;

  logic [CH_NUM-1:0]       valid_q;
  logic [CH_NUM-1:0]       req_rise;
  logic [CH_NUM-1:0]       pending;
  logic [CH_NUM-1:0]       issue_clr;
  logic [CH_NUM-1:0]       accept;
  logic [CH_NUM-1:0]       overflow;
  logic [ADDR_WIDTH-1:0]   lat_addr [CH_NUM];
  logic [WR_NUM_WIDTH-1:0] lat_num  [CH_NUM];
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        gnt;
  logic [IDX_W-1:0]        pick_gnt;
  logic                    pick_any;
  logic                    done_q;
  logic                    done_rise;
  logic                    timeout_hit;
  logic                    wait_end;

  rr_picker #(
    .CH_NUM (CH_NUM),
    .IDX_W  (IDX_W)
  ) u_picker (
    .pending (pending),
    .ptr     (rr_ptr),
    .gnt     (pick_gnt),
    .any     (pick_any)
  );

  assign done_rise = ddr_done & ~done_q;
  assign wait_end  = (state == ST_WAIT) && (done_rise || timeout_hit);

  // The granted channel may re-request in its own ISSUE cycle; that set wins over the clear.
  always_comb begin
    issue_clr = '0;
    if (state == ST_ISSUE) issue_clr[gnt] = 1'b1;
  end

  assign accept   = req_rise & (~pending | issue_clr);
  assign overflow = req_rise & pending & ~issue_clr;

  always_comb begin
    state_nxt      = state;
    busy           = 1'b1;
    ddr_addr_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (pick_any) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        ddr_addr_valid = 1'b1;
        state_nxt      = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_end) state_nxt = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      valid_q  <= '0;
      req_rise <= '0;
      pending  <= '0;
      done_q   <= 1'b0;
      rr_ptr   <= '0;
      gnt      <= '0;
      ch_done  <= '0;
      ddr_addr <= '0;
      ddr_num  <= '0;
      ovf_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      valid_q  <= ch_valid;
      req_rise <= ch_valid & ~valid_q;
      done_q   <= ddr_done;
      pending  <= (pending & ~issue_clr) | accept;
      ovf_err  <= ovf_err | (|overflow);
      ch_done  <= '0;

      // Command fields are loaded on the way into ISSUE so they are stable during the strobe.
      if (state == ST_IDLE && pick_any) begin
        gnt      <= pick_gnt;
        ddr_addr <= lat_addr[pick_gnt];
        ddr_num  <= lat_num[pick_gnt];
      end

      if (wait_end) begin
        ch_done[gnt] <= 1'b1;
        rr_ptr       <= (gnt == IDX_W'(CH_NUM - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

  // NOTE: the request holding registers are cleared on reset so a stale address can never be issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        lat_addr[i] <= '0;
        lat_num[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (accept[i]) begin
          lat_addr[i] <= ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          lat_num[i]  <= ch_num[i*WR_NUM_WIDTH +: WR_NUM_WIDTH];
        end
      end
    end
  end

`ifdef DDR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Fires in the TIMEOUT_CYC-th cycle spent in WAIT.
  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      if (timeout_hit && !done_rise) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Scoreboard bench for ddr_wr_arbiter: stimulus pushes expected commands, a monitor checks strobes and ch_done.
module tb_ddr_wr_arbiter;

  localparam int CH_NUM = 4;
  localparam int AW     = 30;
  localparam int NW     = 28;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [CH_NUM-1:0]      ch_valid;
  logic [CH_NUM*AW-1:0]   ch_addr;
  logic [CH_NUM*NW-1:0]   ch_num;
  logic [CH_NUM-1:0]      ch_done;
  logic                   ddr_addr_valid;
  logic [AW-1:0]          ddr_addr;
  logic [NW-1:0]          ddr_num;
  logic                   ddr_done;
  logic                   busy;
  logic                   ovf_err;
`ifdef DDR_ARB_TIMEOUT_EN
  logic                   timeout_err;
`endif

  ddr_wr_arbiter #(
    .CH_NUM       (CH_NUM),
    .ADDR_WIDTH   (AW),
`ifdef DDR_ARB_TIMEOUT_EN
    .TIMEOUT_CYC  (16),
`endif
    .WR_NUM_WIDTH (NW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ch_valid       (ch_valid),
    .ch_addr        (ch_addr),
    .ch_num         (ch_num),
    .ch_done        (ch_done),
    .ddr_addr_valid (ddr_addr_valid),
    .ddr_addr       (ddr_addr),
    .ddr_num        (ddr_num),
    .ddr_done       (ddr_done),
    .busy           (busy),
`ifdef DDR_ARB_TIMEOUT_EN
    .timeout_err    (timeout_err),
`endif
    .ovf_err        (ovf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    logic [AW-1:0] addr;
    logic [NW-1:0] num;
  } cmd_t;

  cmd_t exp_q[$];
  int   owner_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe pops one expected command; every ch_done pops the owner of the oldest command.
  cmd_t mon_cmd;
  int   mon_owner;
  always @(negedge clk) begin
    if (!rst) begin
      if (ddr_addr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", ddr_addr_valid, 0);
        end else begin
          mon_cmd = exp_q.pop_front();
          check("cmd_addr", ddr_addr, mon_cmd.addr);
          check("cmd_num", ddr_num, mon_cmd.num);
          owner_q.push_back(mon_cmd.ch);
        end
      end
      if (ch_done != '0) begin
        if (owner_q.size() == 0) begin
          check("unexpected_ch_done", ch_done, 0);
        end else begin
          mon_owner = owner_q.pop_front();
          check("ch_done_owner", ch_done, 64'd1 << mon_owner);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic [AW-1:0] a, input logic [NW-1:0] n, input bit expect_cmd);
    cmd_t c;
    ch_addr[ch*AW +: AW] = a;
    ch_num[ch*NW +: NW]  = n;
    ch_valid[ch]         = 1'b1;
    if (expect_cmd) begin
      c.ch = ch; c.addr = a; c.num = n;
      exp_q.push_back(c);
    end
  endtask

  task automatic wait_strobe(output int c);
    bit seen;
    seen = 1'b0;
    c    = cyc;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ddr_addr_valid) begin
        seen = 1'b1;
        c    = cyc;
      end
    end
    if (!seen) check("strobe_wait", ddr_addr_valid, 1);
  endtask

  // Called right after wait_strobe: raises ddr_done in the first WAIT cycle for one cycle.
  task automatic do_done(output int d);
    tick();
    ddr_done = 1'b1;
    d        = cyc;
    tick();
    ddr_done = 1'b0;
  endtask

  task automatic reset_dut();
    rst      = 1'b1;
    ch_valid = '0;
    ddr_done = 1'b0;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    owner_q.delete();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, s, d, t;
    bit found;
    ch_valid = '0;
    ch_addr  = '0;
    ch_num   = '0;
    ddr_done = 1'b0;
    rst      = 1'b1;
    tick(3);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_strobe", ddr_addr_valid, 0);
    check("rst_ch_done", ch_done, 0);
    check("rst_ddr_addr", ddr_addr, 0);
    check("rst_ddr_num", ddr_num, 0);
    check("rst_ovf", ovf_err, 0);
    rst = 1'b0;
    tick();

    // 1: single request on ch1
    set_req(1, 30'h0100_0000, 28'd7200, 1);
    c0 = cyc;
    tick();
    ch_valid[1] = 1'b0;
    wait_strobe(s);
    check("t1_latency", s - c0, 3);
    check("t1_busy_issue", busy, 1);
    do_done(d);
    check("t1_busy_after_done", busy, 0);
    tick(3);

    // 1b: re-request arriving in the ISSUE cycle of the same channel is kept
    reset_dut();
    set_req(1, 30'h0110_0000, 28'd64, 1);
    c0 = cyc;
    tick();
    ch_valid[1] = 1'b0;
    tick();
    set_req(1, 30'h0120_0000, 28'd128, 1);
    wait_strobe(s);
    check("t1b_latency", s - c0, 3);
    do_done(d);
    wait_strobe(s);
    check("t1b_second_latency", s - d, 2);
    do_done(d);
    ch_valid[1] = 1'b0;
    check("t1b_no_ovf", ovf_err, 0);
    tick(3);

    // 2: contention, two rounds, pointer wraps back to 0
    reset_dut();
    for (int r = 0; r < 2; r++) begin
      for (int ch = 0; ch < CH_NUM; ch++)
        set_req(ch, 30'h0200_0000 + AW'(r * 'h10_0000) + AW'(ch * 'h1000), NW'(100 + r * 10 + ch), 1);
      c0 = cyc;
      tick();
      ch_valid = '0;
      wait_strobe(s);
      check("t2_latency", s - c0, 3);
      for (int k = 0; k < CH_NUM; k++) begin
        do_done(d);
        if (k < CH_NUM - 1) begin
          wait_strobe(s);
          check("t2_b2b_latency", s - d, 2);
        end
      end
      tick(2);
      check("t2_idle", busy, 0);
    end

    // 4: spurious done in IDLE
    reset_dut();
    ddr_done = 1'b1;
    tick();
    ddr_done = 1'b0;
    tick(3);
    check("t4_busy", busy, 0);
    check("t4_strobe", ddr_addr_valid, 0);

    // 3: overflow on ch2 while the engine is busy with ch0
    reset_dut();
    set_req(0, 30'h0300_0000, 28'd11, 1);
    tick();
    ch_valid[0] = 1'b0;
    wait_strobe(s);
    tick();
    set_req(2, 30'h0310_0000, 28'd22, 1);
    tick();
    ch_valid[2] = 1'b0;
    tick();
    set_req(2, 30'h0320_0000, 28'd33, 0);
    tick(2);
    check("t3_ovf_set", ovf_err, 1);
    do_done(d);
    wait_strobe(s);
    check("t3_ch2_latency", s - d, 2);
    do_done(d);
    ch_valid[2] = 1'b0;
    tick(10);
    check("t3_ovf_sticky", ovf_err, 1);

    // 5: reset while in WAIT (no reset beforehand, ovf_err still set)
    set_req(3, 30'h0400_0000, 28'd44, 1);
    tick();
    ch_valid[3] = 1'b0;
    wait_strobe(s);
    tick();
    rst = 1'b1;
    tick();
    check("t5_busy", busy, 0);
    check("t5_ch_done", ch_done, 0);
    check("t5_strobe", ddr_addr_valid, 0);
    check("t5_ddr_addr", ddr_addr, 0);
    check("t5_ddr_num", ddr_num, 0);
    check("t5_ovf", ovf_err, 0);
    rst = 1'b0;
    exp_q.delete();
    owner_q.delete();
    tick(2);
    ddr_done = 1'b1;
    tick();
    ddr_done = 1'b0;
    tick(3);
    check("t5_busy_after_late_done", busy, 0);

`ifdef DDR_ARB_TIMEOUT_EN
    // 6: watchdog expiry after 16 WAIT cycles
    reset_dut();
    check("t6_timeout_clear", timeout_err, 0);
    set_req(1, 30'h0500_0000, 28'd55, 1);
    tick();
    ch_valid[1] = 1'b0;
    wait_strobe(s);
    found = 1'b0;
    t     = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ch_done != '0) begin
        found = 1'b1;
        t     = cyc;
        break;
      end
    end
    check("t6_done_seen", found, 1);
    check("t6_timeout_cycle", t - s, 17);
    check("t6_timeout_err", timeout_err, 1);
    tick();
    check("t6_busy", busy, 0);
`endif

    tick(3);
    check("exp_queue_empty", exp_q.size(), 0);
    check("owner_queue_empty", owner_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
